// File: rtl/axil2native_adapter.sv
// axil2native_adapter: AXI4-Lite slave that replays each read or write as one native valid/ready access.
// Build option: define AXIL2NATIVE_WR_FIRST_EN to give writes fixed priority over reads (default is round-robin).
module axil2native_adapter #(
   parameter int AXIL_ADDR_W = 32,
   parameter int AXIL_DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AXIL_ADDR_W-1:0]     s_axil_awaddr,
   input  logic [2:0]                 s_axil_awprot,
   input  logic                       s_axil_awvalid,
   output logic                       s_axil_awready,
   input  logic [AXIL_DATA_W-1:0]     s_axil_wdata,
   input  logic [AXIL_DATA_W/8-1:0]   s_axil_wstrb,
   input  logic                       s_axil_wvalid,
   output logic                       s_axil_wready,
   output logic [1:0]                 s_axil_bresp,
   output logic                       s_axil_bvalid,
   input  logic                       s_axil_bready,
   input  logic [AXIL_ADDR_W-1:0]     s_axil_araddr,
   input  logic [2:0]                 s_axil_arprot,
   input  logic                       s_axil_arvalid,
   output logic                       s_axil_arready,
   output logic [AXIL_DATA_W-1:0]     s_axil_rdata,
   output logic [1:0]                 s_axil_rresp,
   output logic                       s_axil_rvalid,
   input  logic                       s_axil_rready,
   output logic                       valid,
   output logic [AXIL_ADDR_W-1:0]     addr,
   output logic [AXIL_DATA_W-1:0]     wdata,
   output logic [AXIL_DATA_W/8-1:0]   wstrb,
   input  logic [AXIL_DATA_W-1:0]     rdata,
   input  logic                       ready
);

   localparam int STRB_W = AXIL_DATA_W / 8;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_REQ  = 3'd1;
   localparam logic [2:0] S_RD_REQ  = 3'd2;
   localparam logic [2:0] S_WR_RESP = 3'd3;
   localparam logic [2:0] S_RD_RESP = 3'd4;

   logic [2:0]             r_state;
   logic                   r_awFull;
   logic                   r_wFull;
   logic                   r_arFull;
   logic [AXIL_ADDR_W-1:0] r_awAddr;
   logic [AXIL_DATA_W-1:0] r_wData;
   logic [STRB_W-1:0]      r_wStrb;
   logic [AXIL_ADDR_W-1:0] r_arAddr;
   logic                   r_valid;
   logic [AXIL_ADDR_W-1:0] r_addr;
   logic [AXIL_DATA_W-1:0] r_wdata;
   logic [STRB_W-1:0]      r_wstrb;
   logic [AXIL_DATA_W-1:0] r_rdata;
   logic                   r_bvalid;
   logic                   r_rvalid;

   logic w_awHs;
   logic w_wHs;
   logic w_arHs;
   logic w_wrPend;
   logic w_rdPend;
   logic w_pickWr;
   logic w_unusedProt;

   // Buffer readiness depends only on the holding flags, gated off while reset is held.
   assign s_axil_awready = !r_awFull && !rst;
   assign s_axil_wready  = !r_wFull && !rst;
   assign s_axil_arready = !r_arFull && !rst;

   assign w_awHs   = s_axil_awvalid && s_axil_awready;
   assign w_wHs    = s_axil_wvalid && s_axil_wready;
   assign w_arHs   = s_axil_arvalid && s_axil_arready;
   assign w_wrPend = r_awFull && r_wFull;
   assign w_rdPend = r_arFull;

`ifdef AXIL2NATIVE_WR_FIRST_EN
   assign w_pickWr = w_wrPend;
`else
   logic r_lastWr;

   // A tie goes to the opposite type of whatever was served last; reset counts as "write".
   assign w_pickWr = w_wrPend && (!w_rdPend || !r_lastWr);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lastWr <= 1'b1;
      end else if (r_state == S_IDLE && (w_wrPend || w_rdPend)) begin
         r_lastWr <= w_pickWr;
      end
   end
`endif

   assign w_unusedProt = ^{s_axil_awprot, s_axil_arprot};

   assign valid         = r_valid;
   assign addr          = r_addr;
   assign wdata         = r_wdata;
   assign wstrb         = r_wstrb;
   assign s_axil_bvalid = r_bvalid;
   assign s_axil_bresp  = 2'b00;
   assign s_axil_rvalid = r_rvalid;
   assign s_axil_rdata  = r_rdata;
   assign s_axil_rresp  = 2'b00;

   // Channel buffers fill on their handshakes; the FSM drains them one native access at a time.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_awFull <= 1'b0;
         r_wFull  <= 1'b0;
         r_arFull <= 1'b0;
         r_awAddr <= '0;
         r_wData  <= '0;
         r_wStrb  <= '0;
         r_arAddr <= '0;
         r_valid  <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_rdata  <= '0;
         r_bvalid <= 1'b0;
         r_rvalid <= 1'b0;
      end else begin
         if (w_awHs) begin
            r_awFull <= 1'b1;
            r_awAddr <= s_axil_awaddr;
         end
         if (w_wHs) begin
            r_wFull <= 1'b1;
            r_wData <= s_axil_wdata;
            r_wStrb <= s_axil_wstrb;
         end
         if (w_arHs) begin
            r_arFull <= 1'b1;
            r_arAddr <= s_axil_araddr;
         end

         case (r_state)
            S_IDLE: begin
               if (w_pickWr) begin
                  // An all-zero strobe writes nothing, so answer straight away without a native access.
                  if (r_wStrb == '0) begin
                     r_awFull <= 1'b0;
                     r_wFull  <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_state  <= S_WR_RESP;
                  end else begin
                     r_valid <= 1'b1;
                     r_addr  <= r_awAddr;
                     r_wdata <= r_wData;
                     r_wstrb <= r_wStrb;
                     r_state <= S_WR_REQ;
                  end
               end else if (w_rdPend) begin
                  r_valid <= 1'b1;
                  r_addr  <= r_arAddr;
                  r_wdata <= '0;
                  r_wstrb <= '0;
                  r_state <= S_RD_REQ;
               end
            end
            S_WR_REQ: begin
               if (ready) begin
                  r_valid  <= 1'b0;
                  r_awFull <= 1'b0;
                  r_wFull  <= 1'b0;
                  r_bvalid <= 1'b1;
                  r_state  <= S_WR_RESP;
               end
            end
            S_RD_REQ: begin
               if (ready) begin
                  r_valid  <= 1'b0;
                  r_rdata  <= rdata;
                  r_arFull <= 1'b0;
                  r_rvalid <= 1'b1;
                  r_state  <= S_RD_RESP;
               end
            end
            S_WR_RESP: begin
               if (s_axil_bready) begin
                  r_bvalid <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            S_RD_RESP: begin
               if (s_axil_rready) begin
                  r_rvalid <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axil2native_adapter.sv
// tb_axil2native_adapter: directed bench with a transaction-level scoreboard for the AXI4-Lite to native bridge.
// The AXIL2NATIVE_WR_FIRST_EN macro selects which arbitration rule the model expects.
module tb_axil2native_adapter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_axil_awaddr = '0;
   logic [2:0]  s_axil_awprot = '0;
   logic        s_axil_awvalid = 1'b0;
   logic        s_axil_awready;
   logic [31:0] s_axil_wdata = '0;
   logic [3:0]  s_axil_wstrb = '0;
   logic        s_axil_wvalid = 1'b0;
   logic        s_axil_wready;
   logic [1:0]  s_axil_bresp;
   logic        s_axil_bvalid;
   logic        s_axil_bready = 1'b0;
   logic [31:0] s_axil_araddr = '0;
   logic [2:0]  s_axil_arprot = '0;
   logic        s_axil_arvalid = 1'b0;
   logic        s_axil_arready;
   logic [31:0] s_axil_rdata;
   logic [1:0]  s_axil_rresp;
   logic        s_axil_rvalid;
   logic        s_axil_rready = 1'b0;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata = '0;
   logic        ready = 1'b0;

`ifdef AXIL2NATIVE_WR_FIRST_EN
   localparam bit WR_FIRST = 1'b1;
`else
   localparam bit WR_FIRST = 1'b0;
`endif

   axil2native_adapter #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
      .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
      .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
      .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
      .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
      .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
      .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
      .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .rdata(rdata), .ready(ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } natT;

   typedef struct {
      bit          isRead;
      logic [31:0] data;
   } respT;

   natT   expNat[$];
   respT  expResp[$];
   string servedLog = "";
   logic [31:0] periphMem [logic [31:0]];
   int    perDelay = 0;
   bit    spurious = 1'b0;
   int    validRiseCyc = -1;
   int    readyCyc = -1;
   int    natCount = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkStr(input string name, input string act, input string exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got \"%s\", wanted \"%s\"", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic natT mkNat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      natT n;
      n.addr  = a;
      n.wdata = d;
      n.wstrb = s;
      return n;
   endfunction

   // Native peripheral: answers each access perDelay cycles after valid rises and keeps a byte-lane memory.
   initial begin
      int age;
      logic [31:0] word;
      age = 0;
      forever begin
         tick();
         if (valid && !rst) age++;
         else age = 0;
         if (valid && !rst && age == perDelay + 1) begin
            ready = 1'b1;
            if (wstrb == 4'h0) begin
               rdata = periphMem.exists(addr) ? periphMem[addr] : 32'h0;
            end else begin
               word = periphMem.exists(addr) ? periphMem[addr] : 32'h0;
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
               periphMem[addr] = word;
               rdata = 32'h0;
            end
         end else if (spurious && !valid) begin
            ready = 1'b1;
            rdata = 32'h5A5A5A5A;
         end else begin
            ready = 1'b0;
         end
      end
   end

   // Scoreboard: every native request must match the next expected access, every response the next completion.
   initial begin
      bit  natActive, bActive, rActive;
      natT cur;
      respT r;
      natActive = 0; bActive = 0; rActive = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            natActive = 0; bActive = 0; rActive = 0;
            expResp.delete();
         end else begin
            if (valid) begin
               if (!natActive) begin
                  natActive = 1;
                  validRiseCyc = cyc;
                  natCount++;
                  if (wstrb == 4'h0) servedLog = {servedLog, "R"};
                  else servedLog = {servedLog, "W"};
                  checkOutput("natPending", 32'(expNat.size() != 0), 32'd1);
                  if (expNat.size() != 0) begin
                     cur = expNat.pop_front();
                     checkOutput("natAddr", addr, cur.addr);
                     checkOutput("natWdata", wdata, cur.wdata);
                     checkOutput("natWstrb", 32'(wstrb), 32'(cur.wstrb));
                  end
               end else begin
                  checkOutput("natAddrHold", addr, cur.addr);
                  checkOutput("natWdataHold", wdata, cur.wdata);
                  checkOutput("natWstrbHold", 32'(wstrb), 32'(cur.wstrb));
               end
               if (ready) begin
                  natActive = 0;
                  readyCyc = cyc;
                  r.isRead = (wstrb == 4'h0);
                  r.data = rdata;
                  expResp.push_back(r);
               end
            end else if (natActive) begin
               checkOutput("validHeld", 32'(valid), 32'd1);
               natActive = 0;
            end

            if (s_axil_bvalid) begin
               checkOutput("bresp", 32'(s_axil_bresp), 32'd0);
               if (!bActive) begin
                  bActive = 1;
                  checkOutput("bExpected", 32'(expResp.size() != 0 && !expResp[0].isRead), 32'd1);
               end
               if (s_axil_bready) begin
                  bActive = 0;
                  if (expResp.size() != 0 && !expResp[0].isRead) void'(expResp.pop_front());
               end
            end

            if (s_axil_rvalid) begin
               checkOutput("rresp", 32'(s_axil_rresp), 32'd0);
               if (!rActive) begin
                  rActive = 1;
                  checkOutput("rExpected", 32'(expResp.size() != 0 && expResp[0].isRead), 32'd1);
               end
               if (expResp.size() != 0 && expResp[0].isRead)
                  checkOutput("rdata", s_axil_rdata, expResp[0].data);
               if (s_axil_rready) begin
                  rActive = 0;
                  if (expResp.size() != 0 && expResp[0].isRead) void'(expResp.pop_front());
               end
            end
         end
      end
   end

   task automatic sendAw(input logic [31:0] a, output int hs);
      hs = -1;
      s_axil_awaddr = a;
      s_axil_awvalid = 1'b1;
      for (int i = 0; i < 200 && hs < 0; i++) begin
         if (s_axil_awready) hs = cyc;
         tick();
      end
      s_axil_awvalid = 1'b0;
      if (hs < 0) timeoutFail("awAccept");
   endtask

   task automatic sendW(input logic [31:0] d, input logic [3:0] s, output int hs);
      hs = -1;
      s_axil_wdata = d;
      s_axil_wstrb = s;
      s_axil_wvalid = 1'b1;
      for (int i = 0; i < 200 && hs < 0; i++) begin
         if (s_axil_wready) hs = cyc;
         tick();
      end
      s_axil_wvalid = 1'b0;
      if (hs < 0) timeoutFail("wAccept");
   endtask

   task automatic sendAr(input logic [31:0] a, output int hs);
      hs = -1;
      s_axil_araddr = a;
      s_axil_arvalid = 1'b1;
      for (int i = 0; i < 200 && hs < 0; i++) begin
         if (s_axil_arready) hs = cyc;
         tick();
      end
      s_axil_arvalid = 1'b0;
      if (hs < 0) timeoutFail("arAccept");
   endtask

   task automatic takeB(input int holdOff, output int rise);
      rise = -1;
      for (int i = 0; i < 200; i++) begin
         if (s_axil_bvalid) begin
            rise = cyc;
            break;
         end
         tick();
      end
      if (rise < 0) begin
         timeoutFail("bvalidWait");
      end else begin
         repeat (holdOff) tick();
         s_axil_bready = 1'b1;
         tick();
         s_axil_bready = 1'b0;
      end
   endtask

   task automatic takeR(input int holdOff, input logic [31:0] expLit, output int rise);
      rise = -1;
      for (int i = 0; i < 200; i++) begin
         if (s_axil_rvalid) begin
            rise = cyc;
            break;
         end
         tick();
      end
      if (rise < 0) begin
         timeoutFail("rvalidWait");
      end else begin
         for (int h = 0; h < holdOff; h++) begin
            checkOutput("rvalidHold", 32'(s_axil_rvalid), 32'd1);
            checkOutput("rdataHold", s_axil_rdata, expLit);
            tick();
         end
         checkOutput("rdataLit", s_axil_rdata, expLit);
         s_axil_rready = 1'b1;
         tick();
         s_axil_rready = 1'b0;
      end
   endtask

   // Directed scenarios: reset, single write, W-before-AW, read with stall, zero strobe, stray ready, reset abort, contention.
   task automatic applyStimulus();
      int tA, tW, tR, bRise, rRise, leaks, n0, got;
      string order;
      bit lastWr, pickW;
      int wi, ri;

      rst = 1'b1;
      repeat (3) tick();
      checkOutput("rstAwready", 32'(s_axil_awready), 32'd0);
      checkOutput("rstWready", 32'(s_axil_wready), 32'd0);
      checkOutput("rstArready", 32'(s_axil_arready), 32'd0);
      checkOutput("rstValid", 32'(valid), 32'd0);
      checkOutput("rstBvalid", 32'(s_axil_bvalid), 32'd0);
      checkOutput("rstRvalid", 32'(s_axil_rvalid), 32'd0);
      checkOutput("rstAddr", addr, 32'h0);
      checkOutput("rstWdata", wdata, 32'h0);
      checkOutput("rstWstrb", 32'(wstrb), 32'h0);
      checkOutput("rstRdata", s_axil_rdata, 32'h0);
      rst = 1'b0;
      #1;
      checkOutput("postRstAwready", 32'(s_axil_awready), 32'd1);
      checkOutput("postRstArready", 32'(s_axil_arready), 32'd1);
      tick();

      $display("[TB] single write");
      perDelay = 3;
      expNat.push_back(mkNat(32'h10, 32'hDEADBEEF, 4'hF));
      fork
         sendAw(32'h10, tA);
         sendW(32'hDEADBEEF, 4'hF, tW);
      join
      takeB(0, bRise);
      checkOutput("wrValidLat", 32'(validRiseCyc - tA), 32'd2);
      checkOutput("wrReadyLat", 32'(readyCyc - tA), 32'd5);
      checkOutput("wrBvalidLat", 32'(bRise - tA), 32'd6);
      checkOutput("wrMem", periphMem[32'h10], 32'hDEADBEEF);

      $display("[TB] W before AW");
      perDelay = 1;
      expNat.push_back(mkNat(32'h20, 32'h12345678, 4'h3));
      sendW(32'h12345678, 4'h3, tW);
      leaks = 0;
      repeat (3) begin
         if (s_axil_wready) leaks++;
         tick();
      end
      sendAw(32'h20, tA);
      checkOutput("awLate", 32'(tA - tW), 32'd4);
      for (int i = 0; i < 50 && !s_axil_bvalid; i++) begin
         if (s_axil_wready) leaks++;
         tick();
      end
      checkOutput("wreadyLeaks", 32'(leaks), 32'd0);
      takeB(0, bRise);
      checkOutput("wFirstValidLat", 32'(validRiseCyc - tW), 32'd6);
      checkOutput("wFirstBvalidLat", 32'(bRise - tW), 32'd8);
      checkOutput("wreadyAfter", 32'(s_axil_wready), 32'd1);
      checkOutput("strobeMem", periphMem[32'h20], 32'h00005678);

      $display("[TB] read, zero-latency peripheral, rready stalled");
      perDelay = 0;
      periphMem[32'h44] = 32'hCAFEF00D;
      expNat.push_back(mkNat(32'h44, 32'h0, 4'h0));
      sendAr(32'h44, tR);
      takeR(5, 32'hCAFEF00D, rRise);
      checkOutput("rdValidLat", 32'(validRiseCyc - tR), 32'd2);
      checkOutput("rdReadyLat", 32'(readyCyc - tR), 32'd2);
      checkOutput("rdRvalidLat", 32'(rRise - tR), 32'd3);

      $display("[TB] zero-strobe write");
      n0 = natCount;
      begin
         respT zb;
         zb.isRead = 1'b0;
         zb.data = 32'h0;
         expResp.push_back(zb);
      end
      fork
         sendAw(32'h8, tA);
         sendW(32'hFFFFFFFF, 4'h0, tW);
      join
      takeB(1, bRise);
      checkOutput("zeroStrbNoNative", 32'(natCount - n0), 32'd0);
      checkOutput("zeroStrbNoMem", 32'(periphMem.exists(32'h8)), 32'd0);

      $display("[TB] stray ready while idle");
      n0 = natCount;
      spurious = 1'b1;
      tick();
      spurious = 1'b0;
      repeat (2) tick();
      checkOutput("strayBvalid", 32'(s_axil_bvalid), 32'd0);
      checkOutput("strayRvalid", 32'(s_axil_rvalid), 32'd0);
      checkOutput("strayArready", 32'(s_axil_arready), 32'd1);
      checkOutput("strayNative", 32'(natCount - n0), 32'd0);

      $display("[TB] reset during native write");
      perDelay = 10;
      expNat.push_back(mkNat(32'h30, 32'hA5A5A5A5, 4'hF));
      fork
         sendAw(32'h30, tA);
         sendW(32'hA5A5A5A5, 4'hF, tW);
      join
      for (int i = 0; i < 20 && !valid; i++) tick();
      tick();
      rst = 1'b1;
      tick();
      checkOutput("abortValid", 32'(valid), 32'd0);
      checkOutput("abortBvalid", 32'(s_axil_bvalid), 32'd0);
      checkOutput("abortAwready", 32'(s_axil_awready), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("abortAwreadyAfter", 32'(s_axil_awready), 32'd1);
      checkOutput("abortWreadyAfter", 32'(s_axil_wready), 32'd1);
      checkOutput("abortArreadyAfter", 32'(s_axil_arready), 32'd1);
      tick();
      checkOutput("abortNoBvalid", 32'(s_axil_bvalid), 32'd0);
      perDelay = 2;
      periphMem[32'h50] = 32'h0BADF00D;
      expNat.push_back(mkNat(32'h50, 32'h0, 4'h0));
      sendAr(32'h50, tR);
      takeR(0, 32'h0BADF00D, rRise);
      checkOutput("freshRdLat", 32'(rRise - tR), 32'd5);

      $display("[TB] write/read contention");
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      perDelay = 1;
      for (int k = 0; k < 3; k++) periphMem[32'h200 + 32'(4*k)] = 32'hA0000000 + 32'(k);
      lastWr = 1'b1;
      order = "";
      wi = 0;
      ri = 0;
      while (wi < 3 || ri < 3) begin
         if (wi < 3 && ri < 3) pickW = WR_FIRST ? 1'b1 : !lastWr;
         else pickW = (wi < 3);
         if (pickW) begin
            expNat.push_back(mkNat(32'h100 + 32'(4*wi), 32'h11110000 + 32'(wi), 4'hF));
            order = {order, "W"};
            wi++;
         end else begin
            expNat.push_back(mkNat(32'h200 + 32'(4*ri), 32'h0, 4'h0));
            order = {order, "R"};
            ri++;
         end
         lastWr = pickW;
      end
      checkStr("modelOrderPin", order, WR_FIRST ? "WWWRRR" : "RWRWRW");
      servedLog = "";
      got = 0;
      fork
         for (int k = 0; k < 3; k++) begin
            int ha, hw;
            fork
               sendAw(32'h100 + 32'(4*k), ha);
               sendW(32'h11110000 + 32'(k), 4'hF, hw);
            join
         end
         for (int k = 0; k < 3; k++) begin
            int hr;
            sendAr(32'h200 + 32'(4*k), hr);
         end
         begin
            for (int i = 0; i < 400 && got < 6; i++) begin
               if (s_axil_bvalid) s_axil_bready = 1'b1;
               if (s_axil_rvalid) s_axil_rready = 1'b1;
               if (s_axil_bvalid || s_axil_rvalid) got++;
               tick();
               s_axil_bready = 1'b0;
               s_axil_rready = 1'b0;
            end
            if (got < 6) timeoutFail("contentionResponses");
         end
      join
      checkStr("contentionOrder", servedLog, order);
      checkStr("contentionFirst3", servedLog.substr(0, 2), WR_FIRST ? "WWW" : "RWR");
      checkOutput("contentionMem", periphMem[32'h104], 32'h11110001);
      repeat (2) tick();
   endtask

   initial begin
      applyStimulus();
      checkOutput("expNatDrained", 32'(expNat.size()), 32'd0);
      checkOutput("expRespDrained", 32'(expResp.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      total++;
      bad++;
      $display("[TB] FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/axil2native_adapter.md
# axil2native_adapter

AXI4-Lite slave to native-bus master bridge. It accepts AXI4-Lite read and write transactions from an interconnect and replays each one as a single native `valid`/`ready` access to a peripheral. It is the downstream counterpart of the native-to-AXI4-Lite master adapter, and lets native peripherals sit behind an AXI4-Lite fabric. It handles one outstanding native access at a time and buffers one AW, one W and one AR beat.

## Interface
- `AXIL_ADDR_W`, 32, address width (AXI and native).
- `AXIL_DATA_W`, 32, data width; strobe width is `AXIL_DATA_W/8`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `s_axil_awaddr` in ADDR_W; `s_axil_awprot` in 3 (ignored); `s_axil_awvalid` in 1; `s_axil_awready` out 1.
- `s_axil_wdata` in DATA_W; `s_axil_wstrb` in DATA_W/8; `s_axil_wvalid` in 1; `s_axil_wready` out 1.
- `s_axil_bresp` out 2; `s_axil_bvalid` out 1; `s_axil_bready` in 1.
- `s_axil_araddr` in ADDR_W; `s_axil_arprot` in 3 (ignored); `s_axil_arvalid` in 1; `s_axil_arready` out 1.
- `s_axil_rdata` out DATA_W; `s_axil_rresp` out 2; `s_axil_rvalid` out 1; `s_axil_rready` in 1.
- `valid` out 1: native request.
- `addr` out ADDR_W: native address.
- `wdata` out DATA_W: native write data.
- `wstrb` out DATA_W/8: native strobe; 0 means read.
- `rdata` in DATA_W: native read data, valid when `ready` is high.
- `ready` in 1: native completion, a one-cycle pulse.

## Operation
- Holding registers and flags:
  - AW register plus `aw_full`; W register plus `w_full`; AR register plus `ar_full`.
  - `awready = !aw_full`, `wready = !w_full`, `arready = !ar_full`.
  - Each flag is set on its channel handshake.
- AW and W are accepted independently, in either order or in the same cycle.
- FSM states: IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP.
- IDLE:
  - `aw_full && w_full` is a write candidate; `ar_full` is a read candidate.
  - Both pending is arbitrated per Configuration.
  - A write whose stored strobe is all-zero skips the native access: go to WR_RESP and clear `aw_full`/`w_full`.
- WR_REQ:
  - `valid=1`, `addr` = AW register, `wdata`/`wstrb` = W register.
  - On `ready`: clear `aw_full`/`w_full`, go to WR_RESP.
- RD_REQ:
  - `valid=1`, `addr` = AR register, `wstrb=0`, `wdata=0`.
  - On `ready`: capture `rdata` into the R register, clear `ar_full`, go to RD_RESP.
- WR_RESP: `bvalid=1`; on `bready` go to IDLE.
- RD_RESP: `rvalid=1`, `rdata` held; on `rready` go to IDLE.
- `bresp` and `rresp` are always 2'b00 (OKAY).
- Native `valid` stays high, with stable address, data and strobe, until `ready`.
- New AW/W/AR beats are accepted while an access is in flight if their buffer is empty.

## Timing
- Reset:
  - State is IDLE and all flags clear.
  - `valid`, `bvalid` and `rvalid` are 0; `addr`, `wdata`, `wstrb` and `rdata` registers are 0.
  - Ready outputs are 0 while `rst` is high and 1 from the first cycle after.
- Write latency: AW+W handshake at cycle T, `valid` at T+2, `ready` at T+k, `bvalid` at T+k+1.
- Read latency: AR at T, `valid` at T+2, `ready` at T+k, `rvalid` at T+k+1.
- `ready` asserted in the same cycle `valid` rises is legal: the access completes in one cycle.
- `ready` while `valid` is low is ignored.
- Back-to-back: if the response handshakes at T, IDLE is at T+1 and the next `valid` is at T+2.
- Reset mid-operation aborts everything: no response is issued and no native access is in flight afterwards.
- Ready outputs are flag-driven only, with no combinational path from `valid`s.

## Configuration
- Macro `AXIL2NATIVE_WR_FIRST_EN`.
- Defined: when both a write and a read are pending in IDLE, the write always wins.
- Undefined: round-robin. The winner is the opposite type of the last served access. The last-served register resets to "write", so the first tie goes to the read.
- A single pending request is served immediately in both builds.

## Test plan
- Single write:
  - Stimulus: AW addr 0x10 with W 0xDEADBEEF/0xF in the same cycle, peripheral `ready` 3 cycles after `valid`.
  - Required: one native write with `addr=0x10`, `wdata=0xDEADBEEF`, `wstrb=0xF`; then `bvalid` with `bresp=0`.
- W before AW:
  - Stimulus: W 0x12345678/0x3 at T, AW 0x20 at T+4.
  - Required: `valid` no earlier than T+6, with `wstrb=0x3`; `wready` stays low until completion.
- Read:
  - Stimulus: AR 0x44, peripheral returns 0xCAFEF00D with `ready` in the same cycle as `valid`.
  - Required: `rvalid` next cycle with `rdata=0xCAFEF00D`; `rdata` holds while `rready` is held low for 5 cycles.
- Zero-strobe write:
  - Stimulus: AW 0x8, W strobe 0x0.
  - Required: no native `valid`; `bvalid` with OKAY.
- Contention:
  - Stimulus: write and read both pending in IDLE, three times in a row.
  - Required: with the macro, W W W ordering; without it, R W R.
- Reset mid-operation:
  - Stimulus: assert `rst` during WR_REQ.
  - Required: the next cycle `valid=0` and `bvalid=0`; after release, ready outputs are 1 and a fresh read completes normally.
